// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data-SRAM responder: word memory, byte-lane writes, registered reads, optional wait states
module data_sram_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic        stallreq_for_mem
);

    localparam int         LP_DEPTH    = 1 << DEPTH_LOG2;
    localparam bit         LP_HAS_WAIT = (WAIT_CYCLES != 0);
    localparam logic [3:0] LP_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;
    logic [3:0]              r_req_wen;
    logic [DEPTH_LOG2-1:0]   r_req_idx;
    logic [31:0]             r_req_wdata;
    logic [31:0]             r_rdata;
    logic                    r_rvalid;
    logic [31:0]             r_mem [LP_DEPTH];

    logic                    w_capture;
    logic                    w_access;
    logic                    w_stall;
    logic [3:0]              w_acc_wen;
    logic [DEPTH_LOG2-1:0]   w_acc_idx;
    logic [31:0]             w_acc_wdata;
    logic                    w_acc_read;
    logic                    w_acc_write;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_unused_addr;

    // Upper address bits wrap the memory; the byte offset is dropped.
    assign w_idx         = data_sram_addr[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^{data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_access    = 1'b0;
        w_stall     = 1'b0;
        w_acc_wen   = data_sram_wen;
        w_acc_idx   = w_idx;
        w_acc_wdata = data_sram_wdata;
        case (r_state)
            S_IDLE: begin
                if (data_sram_en) begin
                    if (LP_HAS_WAIT) begin
                        w_capture   = 1'b1;
                        w_cnt_nxt   = LP_CNT_INIT;
                        w_state_nxt = S_BUSY;
                        w_stall     = 1'b1;
                    end else begin
                        w_access = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                // Only the captured request is served; the held port request is not re-accepted.
                w_acc_wen   = r_req_wen;
                w_acc_idx   = r_req_idx;
                w_acc_wdata = r_req_wdata;
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    w_stall   = 1'b1;
                end else begin
                    w_access    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_acc_read  = w_access & (w_acc_wen == 4'b0000);
    assign w_acc_write = w_access & (|w_acc_wen);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_wen   <= 4'd0;
            r_req_idx   <= '0;
            r_req_wdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_req_wen   <= data_sram_wen;
                r_req_idx   <= w_idx;
                r_req_wdata <= data_sram_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_acc_read;
            if (w_acc_read) begin
                r_rdata <= r_mem[w_acc_idx];
            end
        end
    end

    // The array has no reset; a write aborted by reset must not land.
    always_ff @(posedge clk) begin
        if (w_acc_write && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_wen[i]) begin
                    r_mem[w_acc_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata  = r_rdata;
    assign data_sram_rvalid = r_rvalid;
    assign stallreq_for_mem = w_stall;

endmodule
